branch_resolve_unit: RTL and testbench

- Parametrised successor to the ID-stage branch comparator.
- Resolves MIPS32 branches and jumps using an extended condition set: equality plus sign tests against zero.
- Holds a PC-indexed table of 2-bit saturating counters that the IF stage reads for a prediction.
- Returns a registered taken/mispredict verdict to the hazard unit one cycle after the branch is presented, and keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_resolve_unit.sv | 97 +++++++++
 tb/tb_branch_resolve_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// ID-stage branch/jump resolver with a PC-indexed 2-bit predictor table
// and saturating branch and mispredict statistics.
module branch_resolve_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int BHT_DEPTH  = 64,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fetchPc,
    output logic                  predictTaken,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    input  logic [2:0]            code,
    input  logic                  predTaken,
    output logic                  resolved,
    output logic                  isBranch,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] branchCount,
    output logic [STAT_WIDTH-1:0] mispredictCount
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] res_idx;
    logic             eq;
    logic             neg;
    logic             zero;
    logic             taken;
    logic             cond;
    logic             miss;
    logic             unused_bits;

    assign fetch_idx    = fetchPc[IDX_W+1:2];
    assign res_idx      = pc[IDX_W+1:2];
    assign predictTaken = bht[fetch_idx][1];

    assign unused_bits = ^{fetchPc[DATA_WIDTH-1:IDX_W+2], fetchPc[1:0],
                           pc[DATA_WIDTH-1:IDX_W+2], pc[1:0]};

    assign eq   = (rs == rt);
    assign neg  = rs[DATA_WIDTH-1];
    assign zero = (rs == '0);

    always_comb begin
        taken = 1'b0;
        cond  = 1'b1;
        unique case (code)
            3'b000: begin taken = 1'b0; cond = 1'b0; end
            3'b001: taken = eq;
            3'b010: taken = !eq;
            3'b011: begin taken = 1'b1; cond = 1'b0; end
            3'b100: taken = neg || zero;
            3'b101: taken = !neg && !zero;
            3'b110: taken = neg;
            3'b111: taken = !neg;
        endcase
    end

    assign miss = taken ^ predTaken;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
            resolved        <= 1'b0;
            isBranch        <= 1'b0;
            mispredict      <= 1'b0;
            branchCount     <= '0;
            mispredictCount <= '0;
        end else begin
            resolved   <= valid;
            isBranch   <= valid && taken;
            mispredict <= valid && miss;
            if (valid && cond) begin
                // 2-bit saturating counter training
                if (taken && bht[res_idx] != 2'b11) begin
                    bht[res_idx] <= bht[res_idx] + 2'b01;
                end else if (!taken && bht[res_idx] != 2'b00) begin
                    bht[res_idx] <= bht[res_idx] - 2'b01;
                end
                if (branchCount != '1) begin
                    branchCount <= branchCount + 1'b1;
                end
            end
            if (valid && miss && mispredictCount != '1) begin
                mispredictCount <= mispredictCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver pushes expected verdicts,
// monitor pops and compares after each clock edge.
module tb_branch_resolve_unit;

    localparam int DW = 32;
    localparam int D  = 64;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] fetchPc;
    logic          predictTaken;
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [2:0]    code;
    logic          predTaken;
    logic          resolved;
    logic          isBranch;
    logic          mispredict;
    logic [SW-1:0] branchCount;
    logic [SW-1:0] mispredictCount;

    branch_resolve_unit #(
        .DATA_WIDTH(DW),
        .BHT_DEPTH(D),
        .STAT_WIDTH(SW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fetchPc(fetchPc),
        .predictTaken(predictTaken),
        .valid(valid),
        .pc(pc),
        .rs(rs),
        .rt(rt),
        .code(code),
        .predTaken(predTaken),
        .resolved(resolved),
        .isBranch(isBranch),
        .mispredict(mispredict),
        .branchCount(branchCount),
        .mispredictCount(mispredictCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        int r;
        int b;
        int m;
        int bc;
        int mc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   bht[D];
    int   bc;
    int   mc;

    function automatic int idx(input logic [DW-1:0] a);
        return int'(a >> 2) % D;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) bht[i] = 1;
        bc = 0;
        mc = 0;
    endtask

    // Reference: evaluate the condition arithmetically on signed rs
    function automatic int ref_taken(input logic [2:0] c,
                                     input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
        int s;
        s = $signed(a);
        case (c)
            3'd0: return 0;
            3'd1: return int'(a == b);
            3'd2: return int'(a != b);
            3'd3: return 1;
            3'd4: return int'(s <= 0);
            3'd5: return int'(s > 0);
            3'd6: return int'(s < 0);
            default: return int'(s >= 0);
        endcase
    endfunction

    task automatic step(input logic v, input logic [DW-1:0] p,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [2:0] c, input logic pt,
                        input logic [DW-1:0] f);
        exp_t e;
        int   t;
        int   mis;
        @(negedge clock);
        valid = v; pc = p; rs = a; rt = b;
        code = c; predTaken = pt; fetchPc = f;
        #1;
        chk("lookup", int'(predictTaken), int'(bht[idx(f)] >= 2));
        if (!v) begin
            e = '{0, 0, 0, bc, mc};
        end else begin
            t   = ref_taken(c, a, b);
            mis = int'(t != int'(pt));
            if (c != 3'd0 && c != 3'd3) begin
                if (t != 0) bht[idx(p)] = (bht[idx(p)] < 3) ? bht[idx(p)] + 1 : 3;
                else        bht[idx(p)] = (bht[idx(p)] > 0) ? bht[idx(p)] - 1 : 0;
                bc = (bc < SMAX) ? bc + 1 : SMAX;
            end
            if (mis != 0) mc = (mc < SMAX) ? mc + 1 : SMAX;
            e = '{1, t, mis, bc, mc};
        end
        q.push_back(e);
    endtask

    task automatic idle(input logic [DW-1:0] f);
        step(1'b0, '0, '0, '0, 3'd0, 1'b0, f);
    endtask

    task automatic mid_reset(input logic [DW-1:0] f);
        @(posedge clock);
        #3;
        reset = 1'b1;
        valid = 1'b0;
        fetchPc = f;
        #1;
        q.delete();
        model_reset();
        chk("rst_resolved", int'(resolved), 0);
        chk("rst_isBranch", int'(isBranch), 0);
        chk("rst_mispredict", int'(mispredict), 0);
        chk("rst_branchCount", int'(branchCount), 0);
        chk("rst_mispredictCount", int'(mispredictCount), 0);
        chk("rst_predict", int'(predictTaken), 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("resolved", int'(resolved), e.r);
                chk("isBranch", int'(isBranch), e.b);
                chk("mispredict", int'(mispredict), e.m);
                chk("branchCount", int'(branchCount), e.bc);
                chk("mispredictCount", int'(mispredictCount), e.mc);
            end
        end
    end

    initial begin : driver
        logic [DW-1:0] vals[4];
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] p;
        int            wait_cycles;

        reset = 1'b1;
        valid = 1'b0; pc = '0; rs = '0; rt = '0;
        code = 3'd0; predTaken = 1'b0; fetchPc = 32'h0040_0010;
        model_reset();
        #12;
        chk("init_predict", int'(predictTaken), 0);
        chk("init_resolved", int'(resolved), 0);
        chk("init_branchCount", int'(branchCount), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < D; i += 7) idle(DW'(i * 4));

        // beq taken trains entry 4 from 01 to 10
        step(1'b1, 32'h0040_0010, 5, 5, 3'd1, 1'b0, 32'h0040_0010);
        idle(32'h0040_0010);

        // saturation then one not-taken
        for (int i = 0; i < 4; i++) step(1'b1, 32'h10, 7, 7, 3'd1, 1'b1, 32'h10);
        step(1'b1, 32'h10, 1, 2, 3'd1, 1'b1, 32'h10);
        idle(32'h10);

        // sign conditions
        for (int c = 4; c < 8; c++)
            step(1'b1, 32'h20, 32'hFFFF_FFFF, 3, 3'(c), 1'b0, 32'h20);
        for (int c = 4; c < 8; c++)
            step(1'b1, 32'h24, 32'h0, 32'h0, 3'(c), 1'b1, 32'h24);
        step(1'b1, 32'h28, 32'h7FFF_FFFF, 0, 3'd5, 1'b0, 32'h28);

        // jump, none-code and collision cases
        step(1'b1, 32'h30, 1, 2, 3'd3, 1'b0, 32'h30);
        step(1'b1, 32'h30, 1, 2, 3'd0, 1'b1, 32'h30);
        step(1'b1, 32'h34, 9, 9, 3'd1, 1'b0, 32'h34);
        step(1'b1, 32'h34, 9, 9, 3'd1, 1'b0, 32'h34);
        idle(32'h34);
        step(1'b1, 32'h38 + 32'h100, 1, 1, 3'd1, 1'b0, 32'h38);
        idle(32'h38);

        // statistics saturation from a clean state
        mid_reset(32'h0040_0010);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h40, 3, 3, 3'd1, 1'b0, 32'h44);
        idle(32'h40);

        // async reset with a resolve in flight
        step(1'b1, 32'h50, 3, 3, 3'd1, 1'b0, 32'h50);
        mid_reset(32'h40);
        for (int i = 0; i < D; i += 5) idle(DW'(i * 4));

        vals[0] = '0;
        vals[1] = 32'd1;
        vals[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 400; i++) begin
            vals[3] = $urandom;
            a = vals[$urandom_range(0, 3)];
            b = ($urandom_range(0, 2) == 0) ? a : vals[$urandom_range(0, 3)];
            p = {$urandom, 2'b00};
            p[DW-1:8] = $urandom;
            p[7:2] = 6'($urandom_range(0, 7));
            step(1'($urandom_range(0, 4) != 0), p, a, b, 3'($urandom),
                 1'($urandom), ($urandom_range(0, 2) == 0) ? p :
                 {24'h0, 2'b00, 4'($urandom_range(0, 7)), 2'b00});
            if (i == 200) mid_reset(p);
        end
        idle('0);

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(posedge clock);
            wait_cycles++;
        end
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
